// File: rtl/rr_packet_arbiter_if.sv
// Queue-side FIFO ports and downstream word port of the round-robin packet arbiter.
interface rr_packet_arbiter_if #(
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 8
);
    localparam int unsigned WORD_W = CTRL_WIDTH + DATA_WIDTH;
    localparam int unsigned QW     = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

    logic [NUM_QUEUES*WORD_W-1:0] in_fifo_dout;
    logic [NUM_QUEUES-1:0]        in_fifo_empty;
    logic [NUM_QUEUES-1:0]        in_fifo_rd_en;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CTRL_WIDTH-1:0]        out_ctrl;
    logic                         out_wr;
    logic                         out_rdy;
    logic [QW-1:0]                cur_queue;

    modport master (
        input  in_fifo_dout, in_fifo_empty, out_rdy,
        output in_fifo_rd_en, out_data, out_ctrl, out_wr, cur_queue
    );

    modport slave (
        output in_fifo_dout, in_fifo_empty, out_rdy,
        input  in_fifo_rd_en, out_data, out_ctrl, out_wr, cur_queue
    );
endinterface

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet scheduler: forwards whole packets from NUM_QUEUES FIFOs onto one
// output word stream, using each FIFO's registered dout as a per-queue head register.
module rr_packet_arbiter #(
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rr_packet_arbiter_if.master  bus
);
    localparam int unsigned WORD_W = CTRL_WIDTH + DATA_WIDTH;
    localparam int unsigned QW     = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t                state_q, state_d;
    logic [QW-1:0]         grant_q, grant_d;
    logic [QW-1:0]         last_q, last_d;
    logic [QW-1:0]         cur_q, cur_d;
    logic [NUM_QUEUES-1:0] head_valid_q, head_valid_d;
    logic                  out_wr_q, out_wr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;

    logic [NUM_QUEUES-1:0] grant_oh_c, consume_c, rd_en_c;
    logic                  grant_valid_c, consume_en_c, found_c;
    logic [WORD_W-1:0]     head_word_c;
    logic [CTRL_WIDTH-1:0] head_ctrl_c;
    logic [QW-1:0]         sel_c;
    int unsigned           dist_c, best_dist_c;

    // Round-robin search: smallest distance past last_grant among queues with a valid head.
    always_comb begin
        sel_c       = '0;
        dist_c      = 0;
        best_dist_c = NUM_QUEUES;
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            dist_c = (q + NUM_QUEUES - 1 - 32'(last_q)) % NUM_QUEUES;
            if (head_valid_q[q] && (dist_c < best_dist_c)) begin
                best_dist_c = dist_c;
                sel_c       = QW'(q);
            end
        end
        found_c = (best_dist_c != NUM_QUEUES);
    end

    // Head word and head status of the granted queue.
    always_comb begin
        grant_oh_c    = '0;
        grant_valid_c = 1'b0;
        head_word_c   = '0;
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            if (grant_q == QW'(q)) begin
                grant_oh_c[q] = 1'b1;
                grant_valid_c = head_valid_q[q];
                head_word_c   = bus.in_fifo_dout[q*WORD_W +: WORD_W];
            end
        end
        head_ctrl_c = head_word_c[WORD_W-1 -: CTRL_WIDTH];
    end

    // Packet FSM: arbitrate in IDLE, hold the grant until the EOP word is consumed.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cur_d        = cur_q;
        out_wr_d     = 1'b0;
        out_data_d   = out_data_q;
        out_ctrl_d   = out_ctrl_q;
        consume_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    grant_d = sel_c;
                    cur_d   = sel_c;
                    state_d = HDR;
                end
            end
            HDR, PAYLOAD: begin
                if (grant_valid_c && bus.out_rdy) begin
                    consume_en_c = 1'b1;
                    out_wr_d     = 1'b1;
                    out_data_d   = head_word_c[DATA_WIDTH-1:0];
                    out_ctrl_d   = head_ctrl_c;
                    if ((state_q == HDR) && (head_ctrl_c == '0)) begin
                        state_d = PAYLOAD;
                    end else if ((state_q == PAYLOAD) && (head_ctrl_c != '0)) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pop a FIFO whenever its head slot is free or being vacated this cycle.
    always_comb begin
        consume_c = grant_oh_c & {NUM_QUEUES{consume_en_c}};
        rd_en_c   = '0;
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            rd_en_c[q] = reset_n & ~bus.in_fifo_empty[q] & (~head_valid_q[q] | consume_c[q]);
        end
        head_valid_d = rd_en_c | (head_valid_q & ~consume_c);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_q       <= QW'(NUM_QUEUES - 1);
            cur_q        <= '0;
            head_valid_q <= '0;
            out_wr_q     <= 1'b0;
            out_data_q   <= '0;
            out_ctrl_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            cur_q        <= cur_d;
            head_valid_q <= head_valid_d;
            out_wr_q     <= out_wr_d;
            out_data_q   <= out_data_d;
            out_ctrl_q   <= out_ctrl_d;
        end
    end

    assign bus.in_fifo_rd_en = rd_en_c;
    assign bus.out_wr        = out_wr_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_ctrl      = out_ctrl_q;
    assign bus.cur_queue     = cur_q;

endmodule
